// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared widths and controller state encodings for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CNT_WIDTH      = 7;

    localparam logic [1:0] PC_RUN   = 2'd0;
    localparam logic [1:0] PC_FLUSH = 2'd1;
    localparam logic [1:0] PC_MULTI = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Pure combinational load-use comparator between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                      i_ex_is_load,
    input  logic                      i_ex_rd_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
    input  logic                      i_id_rs1_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
    input  logic                      i_id_rs2_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
    output logic                      o_load_use
);

    logic w_ex_load_wr;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_ex_load_wr = i_ex_is_load & i_ex_rd_wr_en & (i_ex_rd_addr != '0);
    assign w_rs1_hit    = i_id_rs1_rd_en & (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit    = i_id_rs2_rd_en & (i_id_rs2_addr == i_ex_rd_addr);
    assign o_load_use   = w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller: jump flush, load-use and MDU stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_jump_req,
    input  logic [ADDR_WIDTH-1:0]     ex_jump_addr,
    input  logic                      ex_is_load,
    input  logic                      ex_rd_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      id_rs1_rd_en,
    input  logic                      id_rs2_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      ex_mdu_start,
    input  logic                      ex_mdu_done,
    output logic                      pc_jump_en,
    output logic [ADDR_WIDTH-1:0]     pc_jump_addr,
    output logic                      pc_stall,
    output logic                      if_id_stall,
    output logic                      id_ex_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      mdu_timeout_err
);

    localparam logic [CNT_WIDTH-1:0] c_flush_reload = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_timeout      = CNT_WIDTH'(MDU_TIMEOUT);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic                 w_load_use;
    logic                 w_pc_stall;
    logic                 w_if_id_stall;
    logic                 w_id_ex_stall;

    hazard_detect u_hazard_detect (
        .i_ex_is_load   (ex_is_load),
        .i_ex_rd_wr_en  (ex_rd_wr_en),
        .i_ex_rd_addr   (ex_rd_addr),
        .i_id_rs1_rd_en (id_rs1_rd_en),
        .i_id_rs1_addr  (id_rs1_addr),
        .i_id_rs2_rd_en (id_rs2_rd_en),
        .i_id_rs2_addr  (id_rs2_addr),
        .o_load_use     (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= PC_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        pc_jump_en      = 1'b0;
        pc_jump_addr    = '0;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        mdu_timeout_err = 1'b0;

        case (r_state)
            PC_RUN: begin
                if (ex_jump_req) begin
                    pc_jump_en   = 1'b1;
                    pc_jump_addr = ex_jump_addr;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = PC_FLUSH;
                        w_next_cnt   = c_flush_reload;
                    end
                end else if (ex_mdu_start) begin
                    // stall begins next cycle; a coincident done is ignored
                    w_next_state = PC_MULTI;
                    w_next_cnt   = CNT_WIDTH'(1);
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    id_ex_flush   = 1'b1;
                end
            end

            PC_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (ex_jump_req) begin
                    pc_jump_en   = 1'b1;
                    pc_jump_addr = ex_jump_addr;
                    w_next_cnt   = c_flush_reload;
                end else if (r_cnt <= CNT_WIDTH'(1)) begin
                    w_next_state = PC_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CNT_WIDTH'(1);
                end
            end

            PC_MULTI: begin
                if (ex_mdu_done) begin
                    // leave every control low so the MDU result moves on
                    w_next_state = PC_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_stall = 1'b1;
                    ex_mem_flush  = 1'b1;
                    if (r_cnt >= c_timeout) begin
                        mdu_timeout_err = 1'b1;
                        w_next_state    = PC_RUN;
                        w_next_cnt      = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_next_state = PC_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // a flush on the same register always overrides its stall
    assign pc_stall    = w_pc_stall;
    assign if_id_stall = w_if_id_stall & ~if_id_flush;
    assign id_ex_stall = w_id_ex_stall & ~id_ex_flush;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic        ex_is_load;
    logic        ex_rd_wr_en;
    logic [4:0]  ex_rd_addr;
    logic        id_rs1_rd_en;
    logic        id_rs2_rd_en;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        ex_mdu_start;
    logic        ex_mdu_done;
    logic        pc_jump_en;
    logic [31:0] pc_jump_addr;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mdu_timeout_err;

    int tests;
    int failed;

    // {jump_en, pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush, err}
    localparam logic [7:0] c_idle  = 8'b0000_0000;
    localparam logic [7:0] c_lu    = 8'b0110_0100;
    localparam logic [7:0] c_jump  = 8'b1000_1100;
    localparam logic [7:0] c_flush = 8'b0000_1100;
    localparam logic [7:0] c_multi = 8'b0111_0010;

    pipe_ctrl #(
        .FLUSH_CYCLES (2),
        .MDU_TIMEOUT  (8)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_jump_req     (ex_jump_req),
        .ex_jump_addr    (ex_jump_addr),
        .ex_is_load      (ex_is_load),
        .ex_rd_wr_en     (ex_rd_wr_en),
        .ex_rd_addr      (ex_rd_addr),
        .id_rs1_rd_en    (id_rs1_rd_en),
        .id_rs2_rd_en    (id_rs2_rd_en),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .ex_mdu_start    (ex_mdu_start),
        .ex_mdu_done     (ex_mdu_done),
        .pc_jump_en      (pc_jump_en),
        .pc_jump_addr    (pc_jump_addr),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mdu_timeout_err (mdu_timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] outs();
        return {pc_jump_en, pc_stall, if_id_stall, id_ex_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mdu_timeout_err};
    endfunction

    task automatic idle();
        ex_jump_req  = 1'b0;
        ex_jump_addr = 32'h0;
        ex_is_load   = 1'b0;
        ex_rd_wr_en  = 1'b0;
        ex_rd_addr   = 5'd0;
        id_rs1_rd_en = 1'b0;
        id_rs2_rd_en = 1'b0;
        id_rs1_addr  = 5'd0;
        id_rs2_addr  = 5'd0;
        ex_mdu_start = 1'b0;
        ex_mdu_done  = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs2);
        ex_is_load   = 1'b1;
        ex_rd_wr_en  = 1'b1;
        ex_rd_addr   = rd;
        id_rs2_rd_en = 1'b1;
        id_rs2_addr  = rs2;
    endtask

    // inputs change 1 ns after the rising edge, outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        idle();
        rst_n = 1'b0;
        tick();
        settle();
        o = outs();
        tests++;
        if (o !== c_idle || pc_jump_addr !== 32'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %b addr %h, need %b addr 0", o, pc_jump_addr, c_idle);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0] o;
        idle();
        load_use(5'd5, 5'd5);
        settle();
        o = outs();
        tests++;
        if (o !== c_lu) begin
            failed++;
            $display("FAIL load_use_rs2: got %b need %b", o, c_lu);
        end
        tick();
        idle();
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL load_use_cleared: got %b need %b", o, c_idle);
        end
        tick();
        load_use(5'd0, 5'd0);
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL load_use_x0: got %b need %b", o, c_idle);
        end
        tick();
        idle();
        ex_is_load   = 1'b1;
        ex_rd_wr_en  = 1'b1;
        ex_rd_addr   = 5'd9;
        id_rs1_rd_en = 1'b1;
        id_rs1_addr  = 5'd9;
        settle();
        o = outs();
        tests++;
        if (o !== c_lu) begin
            failed++;
            $display("FAIL load_use_rs1: got %b need %b", o, c_lu);
        end
        tick();
        id_rs1_rd_en = 1'b0;
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL load_use_no_rd_en: got %b need %b", o, c_idle);
        end
        tick();
        idle();
    endtask

    task automatic test_jump();
        logic [7:0] o;
        idle();
        ex_jump_req  = 1'b1;
        ex_jump_addr = 32'h0000_0100;
        settle();
        o = outs();
        tests++;
        if (o !== c_jump || pc_jump_addr !== 32'h0000_0100) begin
            failed++;
            $display("FAIL jump_cycle0: got %b addr %h, need %b addr 00000100", o, pc_jump_addr, c_jump);
        end
        tick();
        idle();
        load_use(5'd5, 5'd5);
        settle();
        o = outs();
        tests++;
        if (o !== c_flush) begin
            failed++;
            $display("FAIL jump_cycle1_flush: got %b need %b", o, c_flush);
        end
        tick();
        idle();
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL jump_cycle2_idle: got %b need %b", o, c_idle);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] o;
        idle();
        ex_jump_req  = 1'b1;
        ex_jump_addr = 32'h0000_0100;
        tick();
        ex_jump_addr = 32'h0000_0200;
        settle();
        o = outs();
        tests++;
        if (o !== c_jump || pc_jump_addr !== 32'h0000_0200) begin
            failed++;
            $display("FAIL b2b_second_jump: got %b addr %h, need %b addr 00000200", o, pc_jump_addr, c_jump);
        end
        tick();
        idle();
        settle();
        o = outs();
        tests++;
        if (o !== c_flush) begin
            failed++;
            $display("FAIL b2b_flush_tail: got %b need %b", o, c_flush);
        end
        tick();
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL b2b_idle: got %b need %b", o, c_idle);
        end
        tick();
    endtask

    task automatic test_mdu();
        logic [7:0] o;
        idle();
        ex_mdu_start = 1'b1;
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL mdu_start_cycle: got %b need %b", o, c_idle);
        end
        tick();
        idle();
        for (int c = 1; c <= 4; c++) begin
            ex_jump_req  = (c == 2);
            ex_jump_addr = 32'h0000_0300;
            settle();
            o = outs();
            tests++;
            if (o !== c_multi) begin
                failed++;
                $display("FAIL mdu_stall_c%0d: got %b need %b", c, o, c_multi);
            end
            tick();
            idle();
        end
        ex_mdu_done = 1'b1;
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL mdu_done_cycle: got %b need %b", o, c_idle);
        end
        tick();
        idle();
        load_use(5'd7, 5'd7);
        settle();
        o = outs();
        tests++;
        if (o !== c_lu) begin
            failed++;
            $display("FAIL mdu_back_in_run: got %b need %b", o, c_lu);
        end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        logic [7:0] o;
        int errs;
        errs = 0;
        idle();
        ex_mdu_start = 1'b1;
        tick();
        idle();
        for (int c = 1; c <= 7; c++) begin
            settle();
            o = outs();
            if (mdu_timeout_err === 1'b1) errs++;
            tests++;
            if (o !== c_multi) begin
                failed++;
                $display("FAIL timeout_stall_c%0d: got %b need %b", c, o, c_multi);
            end
            tick();
        end
        settle();
        tests++;
        if (mdu_timeout_err !== 1'b1 || errs != 0) begin
            failed++;
            $display("FAIL timeout_err_c8: got err=%b early=%0d need err=1 early=0", mdu_timeout_err, errs);
        end
        tick();
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL timeout_after: got %b need %b", o, c_idle);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [7:0] o;
        idle();
        ex_jump_req  = 1'b1;
        ex_jump_addr = 32'h0000_0400;
        ex_mdu_start = 1'b1;
        load_use(5'd3, 5'd3);
        settle();
        o = outs();
        tests++;
        if (o !== c_jump || pc_jump_addr !== 32'h0000_0400) begin
            failed++;
            $display("FAIL prio_jump_wins: got %b addr %h, need %b addr 00000400", o, pc_jump_addr, c_jump);
        end
        tick();
        idle();
        settle();
        o = outs();
        tests++;
        if (o !== c_flush) begin
            failed++;
            $display("FAIL prio_flush_not_multi: got %b need %b", o, c_flush);
        end
        tick();
        settle();
        tick();
        ex_mdu_start = 1'b1;
        ex_mdu_done  = 1'b1;
        tick();
        idle();
        settle();
        o = outs();
        tests++;
        if (o !== c_multi) begin
            failed++;
            $display("FAIL start_done_same: got %b need %b", o, c_multi);
        end
        ex_mdu_done = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid_multi();
        logic [7:0] o;
        idle();
        ex_mdu_start = 1'b1;
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        o = outs();
        tests++;
        if (o !== c_idle) begin
            failed++;
            $display("FAIL reset_mid_multi: got %b need %b", o, c_idle);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            settle();
            o = outs();
            tests++;
            if (o !== c_idle) begin
                failed++;
                $display("FAIL reset_mid_multi_after_c%0d: got %b need %b", c, o, c_idle);
            end
        end
        tick();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        test_reset();
        test_load_use();
        test_jump();
        test_back_to_back();
        test_mdu();
        test_timeout();
        test_priority();
        test_reset_mid_multi();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
